rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the CPU's single synchronous instruction-ROM read port between two requesters:
//  instruction fetch (IF) and data/constant load (LD). One grant per cycle, round-robin.
//  Each granted request returns its data on a fixed-latency pipeline, routed back to the requester.
//  Supports an IF flush (branch) that discards IF responses still in flight.
// PARAMETERS
//  ROM_DATA_WIDTH  16  ROM word width
//  ROM_ADDR_WIDTH  12  ROM address width
//  ROM_LATENCY     1   cycles from rom_addr/rom_re to valid rom_din (legal 1..4)
// PORTS
//  i_clk        in   1    clock, all logic on rising edge
//  i_rst        in   1    reset, asynchronous, active-low
//  i_if_req     in   1    IF read request
//  i_if_addr    in   AW   IF word address
//  o_if_gnt     out  1    IF request accepted this cycle
//  o_if_rvalid  out  1    o_if_rdata valid
//  o_if_rdata   out  DW   IF read data
//  i_if_flush   in   1    discard all in-flight IF reads
//  i_ld_req     in   1    LD read request
//  i_ld_addr    in   AW   LD word address
//  o_ld_gnt     out  1    LD request accepted this cycle
//  o_ld_rvalid  out  1    o_ld_rdata valid
//  o_ld_rdata   out  DW   LD read data
//  rom_addr     out  AW   ROM address
//  rom_re       out  1    ROM read enable
//  rom_din      in   DW   ROM data, valid ROM_LATENCY cycles after rom_re
// BEHAVIOUR
//  Reset (i_rst=0, async): rom_addr=0, rom_re=0, all rvalid=0, rdata=0, tag pipe cleared,
//   last_owner=LD (so IF wins first tie). Gnts are combinational and 0 while in reset.
//  Arbitration (combinational, same cycle): one req -> grant it; both -> grant the one that
//   is NOT last_owner; last_owner updates on every grant. Gnt implies request consumed;
//   requester keeps req/addr stable until gnt. No req -> no gnt, rom_re=0.
//  Issue: rom_addr/rom_re are combinational from the granted addr (rom_addr holds its
//   previous value when idle to limit toggling: registered hold copy).
//  Tag pipe: ROM_LATENCY-deep shift register of {valid, owner}; entry pushed at grant.
//   Response: when tail valid, registered output rvalid pulses 1 cycle for owner, rdata
//   captures rom_din. Total latency gnt->rvalid = ROM_LATENCY+1 cycles; order preserved.
//  rdata holds last value when rvalid=0 (no clear).
//  Throughput: one grant every cycle, no bubbles, no back-pressure on responses.
//  Flush: i_if_flush=1 clears valid on every IF tag in the pipe (including one arriving at
//   the tail this cycle -> o_if_rvalid stays 0 next cycle) and forces o_if_gnt=0 that cycle;
//   LD may be granted during flush even if IF requests. LD tags unaffected.
//  Reset mid-operation: in-flight reads dropped, no rvalid after reset release.
//  ROM_LATENCY outside 1..4: elaboration error ($error in generate).
// TESTING
//  1. Reset with both reqs high -> all outputs 0; first cycle after release IF granted.
//  2. IF only, addrs 0x000..0x003 back-to-back, LATENCY=1 -> 4 gnts in 4 cycles,
//     o_if_rvalid 2 cycles after each gnt with ROM[0..3] in order.
//  3. Both reqs held 6 cycles -> gnts alternate IF,LD,IF,LD,IF,LD; responses routed to
//     correct owner, data matches ROM[addr].
//  4. Flush 1 cycle after IF gnt of 0x010 (LD req pending) -> no o_if_rvalid for 0x010,
//     LD granted in flush cycle and its rvalid delivered.
//  5. LATENCY=3, alternating reqs -> every rvalid exactly 4 cycles after its gnt.
//  6. Assert i_rst mid-stream with 2 reads in flight -> no rvalid afterwards, rom_re=0.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of the synchronous instruction-ROM read port
// between instruction fetch (IF) and data/constant load (LD).
module rom_port_arbiter #(
  parameter int ROM_DATA_WIDTH = 16,
  parameter int ROM_ADDR_WIDTH = 12,
  parameter int ROM_LATENCY    = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_if_req,
  input  logic [ROM_ADDR_WIDTH-1:0] i_if_addr,
  output logic                      o_if_gnt,
  output logic                      o_if_rvalid,
  output logic [ROM_DATA_WIDTH-1:0] o_if_rdata,
  input  logic                      i_if_flush,
  input  logic                      i_ld_req,
  input  logic [ROM_ADDR_WIDTH-1:0] i_ld_addr,
  output logic                      o_ld_gnt,
  output logic                      o_ld_rvalid,
  output logic [ROM_DATA_WIDTH-1:0] o_ld_rdata,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic                      rom_re,
  input  logic [ROM_DATA_WIDTH-1:0] rom_din
);

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LD = 1'b1;

  generate
    if (ROM_LATENCY < 1 || ROM_LATENCY > 4) begin : g_bad_lat
      $error("rom_port_arbiter: ROM_LATENCY must be 1..4");
    end
  endgenerate

  logic                      last_q, last_d;
  logic [ROM_ADDR_WIDTH-1:0] hold_q, hold_d;
  logic [ROM_LATENCY-1:0]    tv_q, tv_d;
  logic [ROM_LATENCY-1:0]    to_q, to_d;
  logic                      if_rv_q, if_rv_d;
  logic                      ld_rv_q, ld_rv_d;
  logic [ROM_DATA_WIDTH-1:0] if_rd_q, if_rd_d;
  logic [ROM_DATA_WIDTH-1:0] ld_rd_q, ld_rd_d;

  logic if_ok, ld_ok;
  logic if_gnt, ld_gnt, gnt;
  logic tail_v, tail_o;

  // A flushing IF never competes, so LD can take the slot.
  always_comb begin
    if_ok  = i_rst & i_if_req & ~i_if_flush;
    ld_ok  = i_rst & i_ld_req;
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    unique case (1'b1)
      (if_ok & ld_ok): begin
        if (last_q == OWN_LD) if_gnt = 1'b1;
        else                  ld_gnt = 1'b1;
      end
      (if_ok & ~ld_ok): if_gnt = 1'b1;
      (~if_ok & ld_ok): ld_gnt = 1'b1;
      default: ;
    endcase
    gnt = if_gnt | ld_gnt;
  end

  always_comb begin
    hold_d = hold_q;
    last_d = last_q;
    if (if_gnt) begin
      hold_d = i_if_addr;
      last_d = OWN_IF;
    end else if (ld_gnt) begin
      hold_d = i_ld_addr;
      last_d = OWN_LD;
    end
  end

  // Tag pipe mirrors the ROM latency; flush kills IF tags in flight.
  always_comb begin
    tv_d    = '0;
    to_d    = '0;
    tv_d[0] = gnt;
    to_d[0] = ld_gnt;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      tv_d[i] = tv_q[i-1]
              & ~(i_if_flush & (to_q[i-1] == OWN_IF));
      to_d[i] = to_q[i-1];
    end
  end

  always_comb begin
    tail_v  = tv_q[ROM_LATENCY-1];
    tail_o  = to_q[ROM_LATENCY-1];
    if_rv_d = tail_v & (tail_o == OWN_IF) & ~i_if_flush;
    ld_rv_d = tail_v & (tail_o == OWN_LD);
    if_rd_d = if_rv_d ? rom_din : if_rd_q;
    ld_rd_d = ld_rv_d ? rom_din : ld_rd_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_q  <= OWN_LD;
      hold_q  <= '0;
      tv_q    <= '0;
      to_q    <= '0;
      if_rv_q <= 1'b0;
      ld_rv_q <= 1'b0;
      if_rd_q <= '0;
      ld_rd_q <= '0;
    end else begin
      last_q  <= last_d;
      hold_q  <= hold_d;
      tv_q    <= tv_d;
      to_q    <= to_d;
      if_rv_q <= if_rv_d;
      ld_rv_q <= ld_rv_d;
      if_rd_q <= if_rd_d;
      ld_rd_q <= ld_rd_d;
    end
  end

  always_comb begin
    o_if_gnt    = if_gnt;
    o_ld_gnt    = ld_gnt;
    rom_re      = gnt;
    rom_addr    = hold_d;
    o_if_rvalid = if_rv_q;
    o_ld_rvalid = ld_rv_q;
    o_if_rdata  = if_rd_q;
    o_ld_rdata  = ld_rd_q;
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: latency-1 and latency-3 instances
// driven in lockstep against a response-queue reference model.
module tb_rom_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, if_req, ld_req, flush;
  logic [AW-1:0] if_addr, ld_addr;

  logic          if_gnt [2];
  logic          ld_gnt [2];
  logic          if_rv  [2];
  logic          ld_rv  [2];
  logic          re     [2];
  logic [AW-1:0] raddr  [2];
  logic [DW-1:0] if_rd  [2];
  logic [DW-1:0] ld_rd  [2];
  logic [DW-1:0] din    [2];

  rom_port_arbiter #(
    .ROM_DATA_WIDTH(DW), .ROM_ADDR_WIDTH(AW), .ROM_LATENCY(1)
  ) u_l1 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt[0]), .o_if_rvalid(if_rv[0]),
    .o_if_rdata(if_rd[0]), .i_if_flush(flush),
    .i_ld_req(ld_req), .i_ld_addr(ld_addr),
    .o_ld_gnt(ld_gnt[0]), .o_ld_rvalid(ld_rv[0]),
    .o_ld_rdata(ld_rd[0]),
    .rom_addr(raddr[0]), .rom_re(re[0]), .rom_din(din[0])
  );

  rom_port_arbiter #(
    .ROM_DATA_WIDTH(DW), .ROM_ADDR_WIDTH(AW), .ROM_LATENCY(3)
  ) u_l3 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt[1]), .o_if_rvalid(if_rv[1]),
    .o_if_rdata(if_rd[1]), .i_if_flush(flush),
    .i_ld_req(ld_req), .i_ld_addr(ld_addr),
    .o_ld_gnt(ld_gnt[1]), .o_ld_rvalid(ld_rv[1]),
    .o_ld_rdata(ld_rd[1]),
    .rom_addr(raddr[1]), .rom_re(re[1]), .rom_din(din[1])
  );

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Synchronous ROM models with 1 and 3 cycles of read latency
  logic [AW-1:0] p1;
  logic [AW-1:0] p3 [3];
  always @(posedge clk) begin
    p1    <= raddr[0];
    p3[0] <= raddr[1];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign din[0] = romf(p1);
  assign din[1] = romf(p3[2]);

  typedef struct {
    int            inst;
    logic          own;
    logic [AW-1:0] addr;
    int            due;
  } resp_t;

  resp_t         q[$];
  int            cyc;
  logic          last_m;
  logic [AW-1:0] hold_m;
  logic [DW-1:0] exp_ifd [2];
  logic [DW-1:0] exp_ldd [2];
  logic          m_ig, m_lg;
  logic          s_ig  [2];
  logic          s_lg  [2];
  logic          s_irv [2];
  logic          s_lrv [2];
  int            n_cmp, n_bad;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc%0d got=%0h exp=%0h",
               nm, k, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic ir, input logic [AW-1:0] ia,
                      input logic lr, input logic [AW-1:0] la,
                      input logic fl);
    logic          ig, lg, eirv, elrv;
    logic [AW-1:0] ea;
    rst = r; if_req = ir; if_addr = ia;
    ld_req = lr; ld_addr = la; flush = fl;
    @(negedge clk);
    if (!r) begin
      q.delete();
      last_m  = 1'b1;
      hold_m  = '0;
      exp_ifd = '{16'h0, 16'h0};
      exp_ldd = '{16'h0, 16'h0};
    end
    ig = r && ir && !fl;
    lg = r && lr;
    if (ig && lg) begin
      if (last_m) lg = 1'b0;
      else        ig = 1'b0;
    end
    ea = ig ? ia : (lg ? la : hold_m);
    for (int k = 0; k < 2; k++) begin
      s_ig[k]  = if_gnt[k];
      s_lg[k]  = ld_gnt[k];
      s_irv[k] = if_rv[k];
      s_lrv[k] = ld_rv[k];
      chk("if_gnt", k, 32'(if_gnt[k]), 32'(ig));
      chk("ld_gnt", k, 32'(ld_gnt[k]), 32'(lg));
      chk("rom_re", k, 32'(re[k]), 32'(ig | lg));
      chk("rom_addr", k, 32'(raddr[k]), 32'(ea));
      eirv = 1'b0;
      elrv = 1'b0;
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].inst == k && q[j].due == cyc) begin
          if (q[j].own) begin
            elrv = 1'b1;
            exp_ldd[k] = romf(q[j].addr);
          end else begin
            eirv = 1'b1;
            exp_ifd[k] = romf(q[j].addr);
          end
          q.delete(j);
        end
      end
      chk("if_rvalid", k, 32'(if_rv[k]), 32'(eirv));
      chk("ld_rvalid", k, 32'(ld_rv[k]), 32'(elrv));
      chk("if_rdata", k, 32'(if_rd[k]), 32'(exp_ifd[k]));
      chk("ld_rdata", k, 32'(ld_rd[k]), 32'(exp_ldd[k]));
    end
    if (fl) begin
      for (int j = q.size() - 1; j >= 0; j--)
        if (!q[j].own) q.delete(j);
    end
    if (ig || lg) begin
      hold_m = ea;
      last_m = lg;
      for (int k = 0; k < 2; k++)
        q.push_back('{k, lg, ea, cyc + lat(k) + 1});
    end
    m_ig = ig;
    m_lg = lg;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
  endtask

  typedef struct {
    logic          r;
    logic          ir;
    logic [AW-1:0] ia;
    logic          lr;
    logic [AW-1:0] la;
    logic          fl;
    logic          eig;
    logic          elg;
  } vec_t;

  vec_t tbl [12];
  int   cnt, irv_cnt, lrv_cnt;
  logic          ip, lp, rfl, rr;
  logic [AW-1:0] ra, rla;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b0; if_req = 1'b0; ld_req = 1'b0; flush = 1'b0;
    if_addr = '0; ld_addr = '0;
    last_m = 1'b1; hold_m = '0;
    exp_ifd = '{16'h0, 16'h0};
    exp_ldd = '{16'h0, 16'h0};

    tbl[0]  = '{1'b0, 1'b1, 12'h1A0, 1'b1, 12'h2B0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 12'h1A1, 1'b1, 12'h2B1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 12'h1A2, 1'b1, 12'h2B1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 12'h1A2, 1'b1, 12'h2B3, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 12'h1A4, 1'b0, 12'h2B3, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 12'h1A5, 1'b1, 12'h2B5, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 12'h1A5, 1'b1, 12'h2B6, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 12'h1A7, 1'b1, 12'h2B7, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 12'h1A8, 1'b1, 12'h2B7, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 12'h1A8, 1'b0, 12'h2B9, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 12'h1A8, 1'b0, 12'h2B9, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 12'h1AB, 1'b1, 12'h2BB, 1'b0, 1'b1, 1'b0};

    @(posedge clk);
    #1;

    // Reset with both requests, then arbitration table
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].ir, tbl[i].ia,
           tbl[i].lr, tbl[i].la, tbl[i].fl);
      for (int k = 0; k < 2; k++) begin
        chk("tbl_if_gnt", k, 32'(s_ig[k]), 32'(tbl[i].eig));
        chk("tbl_ld_gnt", k, 32'(s_lg[k]), 32'(tbl[i].elg));
      end
    end
    idle(5);

    // IF-only back-to-back burst
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, AW'(i), 1'b0, 12'h0, 1'b0);
      if (s_ig[0]) cnt++;
    end
    chk("burst_gnts", 0, 32'(cnt), 32'd4);
    idle(5);

    // Both held after a reset: strict IF/LD alternation
    step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, AW'(12'h020 + i), 1'b1,
           AW'(12'h030 + i), 1'b0);
      chk("alt_if", 0, 32'(s_ig[0]), 32'(i % 2 == 0));
      chk("alt_ld", 1, 32'(s_lg[1]), 32'(i % 2 == 1));
    end
    idle(5);

    // Flush right after IF grant of 0x010 with LD pending
    step(1'b1, 1'b1, 12'h010, 1'b1, 12'h040, 1'b0);
    step(1'b1, 1'b1, 12'h011, 1'b1, 12'h040, 1'b0);
    idle(5);
    step(1'b1, 1'b1, 12'h010, 1'b0, 12'h040, 1'b0);
    chk("fl_if_gnt", 0, 32'(s_ig[0]), 32'd1);
    step(1'b1, 1'b1, 12'h011, 1'b1, 12'h040, 1'b1);
    chk("fl_blk_if", 0, 32'(s_ig[0]), 32'd0);
    chk("fl_ld_gnt", 0, 32'(s_lg[0]), 32'd1);
    irv_cnt = 0;
    lrv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
      if (s_irv[0] || s_irv[1]) irv_cnt++;
      if (s_lrv[0]) lrv_cnt++;
    end
    chk("fl_if_rv", 0, 32'(irv_cnt), 32'd0);
    chk("fl_ld_rv", 0, 32'(lrv_cnt), 32'd1);

    // Reset with two reads in flight
    step(1'b1, 1'b1, 12'h050, 1'b1, 12'h060, 1'b0);
    step(1'b1, 1'b1, 12'h051, 1'b1, 12'h060, 1'b0);
    step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
    step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
    irv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
      for (int k = 0; k < 2; k++)
        if (s_irv[k] || s_lrv[k]) irv_cnt++;
    end
    chk("rst_drop", 0, 32'(irv_cnt), 32'd0);

    // Randomized traffic, requests held until granted
    ip = 1'b0; lp = 1'b0; ra = '0; rla = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1'b1;
        ra = AW'($urandom);
      end
      if (!lp && $urandom_range(0, 2) != 0) begin
        lp = 1'b1;
        rla = AW'($urandom);
      end
      rfl = ($urandom_range(0, 7) == 0);
      rr  = ($urandom_range(0, 99) != 0);
      step(rr, ip, ra, lp, rla, rfl);
      if (m_ig) ip = 1'b0;
      if (m_lg) lp = 1'b0;
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
